vending_machine: RTL and testbench



---
 rtl/vending_machine.sv | 101 ++++++++++
 tb/tb_vending_machine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// Single-product vending controller.
// Moore FSM: coin credit, one-cycle beverage strobe, refund clears credit.
module vending_machine #(
  parameter int PRICE    = 1,
  parameter int CREDIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin,
  input  logic selection,
  input  logic refund,
  output logic beverage
);

  localparam logic [CREDIT_W-1:0] MAX_CREDIT = '1;
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    READY,
    VEND
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_q, coin_d;
  logic                sel_q, sel_d;
  logic                bev_q, bev_d;

  logic                coin_evt;
  logic                sel_evt;
  logic [CREDIT_W-1:0] base;

  function automatic state_t classify(logic [CREDIT_W-1:0] c);
    if (c == '0)
      return IDLE;
    else if (c < PRICE_C)
      return CREDIT;
    else
      return READY;
  endfunction

  function automatic logic [CREDIT_W-1:0] add_coin(
    logic [CREDIT_W-1:0] c,
    logic                evt
  );
    if (evt && c != MAX_CREDIT)
      return c + 1'b1;
    else
      return c;
  endfunction

  // Edge detect, refund > select > coin priority, next credit and state.
  always_comb begin
    coin_evt = coin & ~coin_q;
    sel_evt  = selection & ~sel_q;
    coin_d   = coin;
    sel_d    = selection;
    base     = credit_q;
    credit_d = credit_q;
    state_d  = state_q;

    if (state_q == VEND) begin
      credit_d = add_coin(credit_q, coin_evt);
      state_d  = classify(credit_d);
    end else if (refund) begin
      credit_d = '0;
      state_d  = IDLE;
    end else if (sel_evt && state_q == READY) begin
      base     = credit_q - PRICE_C;
      credit_d = add_coin(base, coin_evt);
      state_d  = VEND;
    end else begin
      credit_d = add_coin(credit_q, coin_evt);
      state_d  = classify(credit_d);
    end

    bev_d = (state_d == VEND);
  end

  // State, credit, edge-detect and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      coin_q   <= 1'b0;
      sel_q    <= 1'b0;
      bev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      coin_q   <= coin_d;
      sel_q    <= sel_d;
      bev_q    <= bev_d;
    end
  end

  assign beverage = bev_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine.
// Three instances cover PRICE=1, PRICE=2 and a 2-bit credit counter.
module tb_vending_machine;

  logic       clk;
  logic       rst_n;
  logic [2:0] coin;
  logic [2:0] sel;
  logic [2:0] rf;
  logic [2:0] bev;

  int total;
  int bad;

  typedef struct {
    logic       b;
    logic [3:0] c;
    string      tag;
  } exp_t;

  exp_t sb[$];

  vending_machine #(.PRICE(1), .CREDIT_W(4)) d0 (
    .clk(clk), .rst_n(rst_n), .coin(coin[0]),
    .selection(sel[0]), .refund(rf[0]), .beverage(bev[0])
  );

  vending_machine #(.PRICE(2), .CREDIT_W(4)) d1 (
    .clk(clk), .rst_n(rst_n), .coin(coin[1]),
    .selection(sel[1]), .refund(rf[1]), .beverage(bev[1])
  );

  vending_machine #(.PRICE(1), .CREDIT_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .coin(coin[2]),
    .selection(sel[2]), .refund(rf[2]), .beverage(bev[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] cr(int k);
    case (k)
      0:       return d0.credit_q;
      1:       return d1.credit_q;
      default: return {2'b00, d2.credit_q};
    endcase
  endfunction

  task automatic check(int k, exp_t e);
    total++;
    assert (bev[k] === e.b) else begin
      bad++;
      $error("FAIL %s bev: got %b want %b", e.tag, bev[k], e.b);
    end
    total++;
    assert (cr(k) === e.c) else begin
      bad++;
      $error("FAIL %s credit: got %0d want %0d", e.tag, cr(k), e.c);
    end
  endtask

  task automatic step(int k, logic c, logic s, logic r,
                      logic eb, logic [3:0] ec, string tag);
    exp_t e;
    coin[k] = c;
    sel[k]  = s;
    rf[k]   = r;
    e.b = eb;
    e.c = ec;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(k, sb.pop_front());
  endtask

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    coin  = '0;
    sel   = '0;
    rf    = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e.b = 1'b0; e.c = 4'd0; e.tag = "por";
    check(0, e);
    rst_n = 1'b1;

    // reset mid-operation while strobe is high
    step(0, 1, 0, 0, 0, 4'd1, "rs_c1");
    step(0, 0, 0, 0, 0, 4'd1, "rs_c1l");
    step(0, 1, 0, 0, 0, 4'd2, "rs_c2");
    step(0, 0, 1, 0, 1, 4'd1, "rs_vend");
    rst_n = 1'b0;
    #1;
    e.b = 1'b0; e.c = 4'd0; e.tag = "rs_async";
    check(0, e);
    repeat (2) @(posedge clk);
    #1;
    check(0, e);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 4'd0, "rs_rel");
    step(0, 0, 0, 0, 0, 4'd0, "rs_idle");

    // coin then refund
    step(0, 1, 0, 0, 0, 4'd1, "cr_c");
    step(0, 1, 0, 0, 0, 4'd1, "cr_hold");
    step(0, 0, 0, 1, 0, 4'd0, "cr_ref");
    step(0, 0, 0, 1, 0, 4'd0, "cr_ref2");
    step(0, 0, 0, 0, 0, 4'd0, "cr_end");

    // coin then select
    step(0, 1, 0, 0, 0, 4'd1, "cs_c");
    step(0, 1, 0, 0, 0, 4'd1, "cs_hold");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 4'd1, "cs_wait");
    step(0, 0, 1, 0, 1, 4'd0, "cs_vend");
    step(0, 0, 1, 0, 0, 4'd0, "cs_hold_sel");
    step(0, 0, 0, 0, 0, 4'd0, "cs_end");

    // insufficient credit with PRICE=2
    step(1, 1, 0, 0, 0, 4'd1, "p2_c1");
    step(1, 0, 0, 0, 0, 4'd1, "p2_c1l");
    step(1, 0, 1, 0, 0, 4'd1, "p2_sel_lo");
    step(1, 0, 0, 0, 0, 4'd1, "p2_idle");
    step(1, 1, 0, 0, 0, 4'd2, "p2_c2");
    step(1, 0, 0, 0, 0, 4'd2, "p2_c2l");
    step(1, 0, 1, 0, 1, 4'd0, "p2_vend");
    step(1, 0, 0, 0, 0, 4'd0, "p2_end");

    // refund beats selection
    step(0, 1, 0, 0, 0, 4'd1, "sim_c");
    step(0, 0, 0, 0, 0, 4'd1, "sim_cl");
    step(0, 0, 1, 1, 0, 4'd0, "sim_ref_sel");
    step(0, 0, 0, 0, 0, 4'd0, "sim_clr");

    // selection plus coin in READY
    step(0, 1, 0, 0, 0, 4'd1, "sc_c");
    step(0, 0, 0, 0, 0, 4'd1, "sc_cl");
    step(0, 1, 1, 0, 1, 4'd1, "sc_vend");
    step(0, 0, 0, 0, 0, 4'd1, "sc_ready");
    step(0, 0, 1, 0, 1, 4'd0, "sc_vend2");
    step(0, 0, 0, 0, 0, 4'd0, "sc_end");

    // refund ignored in VEND, honoured next cycle
    step(0, 1, 0, 0, 0, 4'd1, "vr_c1");
    step(0, 0, 0, 0, 0, 4'd1, "vr_c1l");
    step(0, 1, 0, 0, 0, 4'd2, "vr_c2");
    step(0, 0, 1, 0, 1, 4'd1, "vr_vend");
    step(0, 0, 0, 1, 0, 4'd1, "vr_ign");
    step(0, 0, 0, 1, 0, 4'd0, "vr_ref");
    step(0, 0, 0, 0, 0, 4'd0, "vr_end");

    // saturation with a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      step(2, 1, 0, 0, 0, (i > 3) ? 4'd3 : 4'(i), "sat_c");
      step(2, 0, 0, 0, 0, (i > 3) ? 4'd3 : 4'(i), "sat_cl");
    end
    for (int i = 2; i >= 0; i--) begin
      step(2, 0, 1, 0, 1, 4'(i), "sat_vend");
      step(2, 0, 0, 0, 0, 4'(i), "sat_gap");
    end
    step(2, 0, 1, 0, 0, 4'd0, "sat_empty");
    step(2, 0, 0, 0, 0, 4'd0, "sat_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
